// File: rtl/lamp_input_pkg.sv
// Shared types and default timing constants for the lamp input conditioner.
// No logic, no latency, no backpressure.
package lamp_input_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OCCUPIED = 2'd1,
        HOLD     = 2'd2
    } presence_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 500000000;

endpackage

// File: rtl/debounce_sync.sv
// 2-flop synchroniser plus debouncer with registered rise/fall pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from a settled raw level; no backpressure.
module debounce_sync
    import lamp_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Any edge that agrees with the stable level restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/lamp_input_conditioner.sv
// Conditions buttons and presence sensor into one-cycle lamp commands a/b/c/d.
// Latency: DEBOUNCE_CYCLES+2 edges to a pulse; outputs never stall (no backpressure).
module lamp_input_conditioner
    import lamp_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_mode_raw,
    input  logic btn_manual_raw,
    input  logic presence_raw,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic presence_stable,
    output logic hold_active
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic            pres_level;
    logic            pres_rise;
    logic            pres_fall;
    logic            unused_mode_level;
    logic            unused_mode_fall;
    logic            unused_manual_level;
    logic            unused_manual_fall;
    presence_state_t state_q;
    logic [TW-1:0]   tmr_q;
    logic            tmr_expired;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode_raw),
        .level (unused_mode_level),
        .rise  (a),
        .fall  (unused_mode_fall)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_manual (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_manual_raw),
        .level (unused_manual_level),
        .rise  (b),
        .fall  (unused_manual_fall)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_presence (
        .clk   (clk),
        .rst   (rst),
        .raw   (presence_raw),
        .level (pres_level),
        .rise  (pres_rise),
        .fall  (pres_fall)
    );

    assign tmr_expired = (tmr_q == TMR_LAST);

    // The FSM consumes the debouncer's registered pulses, so state_q/tmr_q trail
    // the presence flip by one edge; the outputs below decode the transition
    // being taken so that they line up with presence_stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pres_rise) begin
                        state_q <= OCCUPIED;
                    end
                end
                OCCUPIED: begin
                    if (pres_fall) begin
                        state_q <= HOLD;
                        tmr_q   <= '0;
                    end
                end
                HOLD: begin
                    if (pres_rise) begin
                        state_q <= OCCUPIED;
                        tmr_q   <= '0;
                    end else if (tmr_expired) begin
                        state_q <= IDLE;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tmr_q   <= '0;
                end
            endcase
        end
    end

    // A rise in HOLD beats a same-edge expiry, so c requires no rise.
    assign d = (state_q == IDLE) && pres_rise;
    assign c = (state_q == HOLD) && !pres_rise && tmr_expired;
    assign hold_active = ((state_q == OCCUPIED) && pres_fall) ||
                         ((state_q == HOLD) && !pres_rise && !tmr_expired);
    assign presence_stable = pres_level;

endmodule

// File: tb/tb_lamp_input_conditioner.sv
// Directed bench for lamp_input_conditioner with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20.
module tb_lamp_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst;
    logic btn_mode_raw;
    logic btn_manual_raw;
    logic presence_raw;
    logic a, b, c, d, presence_stable, hold_active;

    always #5 clk = ~clk;

    lamp_input_conditioner #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_mode_raw    (btn_mode_raw),
        .btn_manual_raw  (btn_manual_raw),
        .presence_raw    (presence_raw),
        .a               (a),
        .b               (b),
        .c               (c),
        .d               (d),
        .presence_stable (presence_stable),
        .hold_active     (hold_active)
    );

    int total = 0;
    int bad   = 0;

    // Observation window: tick k is the cycle after the k-th edge since the window opened.
    int tk;
    int n_a, n_b, n_c, n_d, n_hold, n_cd;
    int f_a, f_b, f_c, f_d, f_hold, l_hold, f_ps1, f_ps0;

    task automatic clear_obs();
        tk = 0;
        n_a = 0; n_b = 0; n_c = 0; n_d = 0; n_hold = 0; n_cd = 0;
        f_a = 0; f_b = 0; f_c = 0; f_d = 0; f_hold = 0; l_hold = 0;
        f_ps1 = 0; f_ps0 = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            tk++;
            if (a) begin n_a++; if (f_a == 0) f_a = tk; end
            if (b) begin n_b++; if (f_b == 0) f_b = tk; end
            if (c) begin n_c++; if (f_c == 0) f_c = tk; end
            if (d) begin n_d++; if (f_d == 0) f_d = tk; end
            if (hold_active) begin
                n_hold++;
                if (f_hold == 0) f_hold = tk;
                l_hold = tk;
            end
            if (presence_stable && f_ps1 == 0) f_ps1 = tk;
            if (!presence_stable && f_ps0 == 0) f_ps0 = tk;
            if (c && d) n_cd++;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, int'(a), 0);
        check({tag, "_b"}, int'(b), 0);
        check({tag, "_c"}, int'(c), 0);
        check({tag, "_d"}, int'(d), 0);
        check({tag, "_pstable"}, int'(presence_stable), 0);
        check({tag, "_hold"}, int'(hold_active), 0);
    endtask

    initial begin
        rst = 1'b1;
        btn_mode_raw = 1'b0;
        btn_manual_raw = 1'b0;
        presence_raw = 1'b0;
        clear_obs();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        run(5);

        // Clean mode press, held 10 cycles, then released
        btn_mode_raw = 1'b1;
        clear_obs();
        run(10);
        btn_mode_raw = 1'b0;
        run(12);
        check("press_a_count", n_a, 1);
        check("press_a_tick", f_a, 6);
        check("press_b_count", n_b, 0);
        check("press_c_count", n_c, 0);
        check("press_d_count", n_d, 0);

        // Manual button bounces 1,0,1,1,0 then settles high
        clear_obs();
        btn_manual_raw = 1'b1; run(1);
        btn_manual_raw = 1'b0; run(1);
        btn_manual_raw = 1'b1; run(2);
        btn_manual_raw = 1'b0; run(1);
        btn_manual_raw = 1'b1; run(15);
        check("bounce_b_count", n_b, 1);
        check("bounce_b_tick", f_b, 11);
        check("bounce_a_count", n_a, 0);
        btn_manual_raw = 1'b0;
        clear_obs();
        run(10);
        check("manual_release_b", n_b, 0);

        // Presence arrives: d together with presence_stable
        presence_raw = 1'b1;
        clear_obs();
        run(10);
        check("occ_d_count", n_d, 1);
        check("occ_d_tick", f_d, 6);
        check("occ_pstable_tick", f_ps1, 6);
        check("occ_c_count", n_c, 0);

        // Vacancy for 30 cycles: HOLD for 20, then c
        presence_raw = 1'b0;
        clear_obs();
        run(32);
        check("vac_pstable_fall", f_ps0, 6);
        check("vac_hold_first", f_hold, 6);
        check("vac_hold_count", n_hold, 20);
        check("vac_c_tick", f_c, 26);
        check("vac_c_count", n_c, 1);
        check("vac_d_count", n_d, 0);
        check("vac_cd_overlap", n_cd, 0);

        // Back in IDLE: a new arrival pulses d again
        presence_raw = 1'b1;
        clear_obs();
        run(10);
        check("idle_again_d", n_d, 1);

        // Presence returns mid-HOLD: no c, no d
        presence_raw = 1'b0;
        clear_obs();
        run(10);
        presence_raw = 1'b1;
        run(20);
        check("ret_hold_count", n_hold, 10);
        check("ret_hold_last", l_hold, 15);
        check("ret_c_count", n_c, 0);
        check("ret_d_count", n_d, 0);

        // Later full vacancy still times out
        presence_raw = 1'b0;
        clear_obs();
        run(32);
        check("ret_vac_c_tick", f_c, 26);
        check("ret_vac_c_count", n_c, 1);

        // Re-occupy, then presence rise on the expiry edge
        presence_raw = 1'b1;
        clear_obs();
        run(10);
        check("coin_pre_d", n_d, 1);
        presence_raw = 1'b0;
        clear_obs();
        run(20);
        presence_raw = 1'b1;
        run(15);
        check("coin_c_count", n_c, 0);
        check("coin_d_count", n_d, 0);
        check("coin_hold_count", n_hold, 20);
        check("coin_pstable", int'(presence_stable), 1);
        // Still OCCUPIED: a vacancy now enters HOLD and times out
        presence_raw = 1'b0;
        clear_obs();
        run(32);
        check("coin_next_hold", n_hold, 20);
        check("coin_next_c_tick", f_c, 26);

        // Reset while in HOLD (timer 15) with mode button held
        presence_raw = 1'b1;
        clear_obs();
        run(10);
        presence_raw = 1'b0;
        btn_mode_raw = 1'b1;
        clear_obs();
        run(21);
        check("prerst_hold", int'(hold_active), 1);
        check("prerst_a_count", n_a, 1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_now");
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst_held");
        rst = 1'b0;
        clear_obs();
        run(30);
        check("postrst_a_count", n_a, 1);
        check("postrst_a_tick", f_a, 6);
        check("postrst_c_count", n_c, 0);
        check("postrst_hold", n_hold, 0);
        check("postrst_d_count", n_d, 0);
        btn_mode_raw = 1'b0;
        run(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lamp_input_conditioner.md
# lamp_input_conditioner

Front-end conditioning stage directly upstream of the lamp-mode FSM. It synchronises and debounces the two user push-buttons and the raw presence sensor. It emits the single-cycle command pulses the FSM consumes: `a` (mode toggle), `b` (manual on/off toggle), `d` (turn lamp on: presence detected) and `c` (turn lamp off: vacancy timeout expired).

## Interface
- DEBOUNCE_CYCLES, default 50000: consecutive cycles a synchronised input must differ from its stable level before the stable level flips; legal range >= 1.
- TIMEOUT_CYCLES, default 500000000: cycles of continuous vacancy before `c` fires; legal range >= 2.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high. Clock is `clk`.
- btn_mode_raw  in  1  raw mode button, asynchronous, bouncing.
- btn_manual_raw  in  1  raw manual button, asynchronous, bouncing.
- presence_raw  in  1  raw presence sensor, 1 = occupied.
- a  out  1  one-cycle pulse on debounced rising edge of btn_mode.
- b  out  1  one-cycle pulse on debounced rising edge of btn_manual.
- c  out  1  one-cycle pulse when the vacancy timeout expires.
- d  out  1  one-cycle pulse when presence is detected from IDLE.
- presence_stable  out  1  debounced presence level.
- hold_active  out  1  high while the vacancy timer is running (state HOLD).

## Operation
- Each raw input passes a 2-flop synchroniser, then a debouncer.
- Debouncer: holds a stable level and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - At each edge where the synchronised value differs from the stable level, the counter increments.
  - At each edge where it equals the stable level, the counter clears to 0.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, the stable level flips, the counter clears, and a registered rise or fall pulse is produced at that same edge.
- `a` and `b` are the debounced rise pulses only; release (fall) produces nothing.
- Presence FSM, states IDLE, OCCUPIED, HOLD:
  - IDLE: on presence rise, go to OCCUPIED and pulse `d`.
  - OCCUPIED: on presence fall, go to HOLD with the timer cleared to 0.
  - HOLD: the timer (width $clog2(TIMEOUT_CYCLES)) increments each edge.
    - On presence rise, go to OCCUPIED and clear the timer. No `d` pulse is produced, because the lamp is already on.
    - When the timer equals TIMEOUT_CYCLES-1 with no rise, go to IDLE and pulse `c`.
  - Same-edge rise and expiry: the rise wins. Next state is OCCUPIED and `c` is not asserted.
- `c` and `d` are never high together. `a`, `b` and `c`/`d` are independent and may coincide; the downstream FSM resolves priority.

## Timing
- Reset values: all outputs 0, synchronisers 0, stable levels 0, counters 0, FSM state IDLE.
- Reset mid-operation: everything returns to reset values immediately, and any pending timeout is lost.
- An input held high across reset release is treated as a new rise. It yields its pulse after the standard latency.
- Button latency: a raw level settled before edge 0 produces a pulse high for exactly the cycle after edge DEBOUNCE_CYCLES+1.
- Bounce rejection: any excursion shorter than DEBOUNCE_CYCLES cycles at the synchroniser output is ignored, and the counter restarts on the next differing cycle.
- `d` latency from a presence_raw rise: same as buttons, DEBOUNCE_CYCLES+2 edges. `d` is asserted at the same edge `presence_stable` rises.
- `c` timing: HOLD is entered at edge E, where `presence_stable` falls. `c` is high for the single cycle after edge E+TIMEOUT_CYCLES.
- Pulses are registered outputs with no combinational path from inputs.

## Structure
- Package `lamp_input_pkg`:
  - enum `presence_state_t` (IDLE, OCCUPIED, HOLD).
  - default DEBOUNCE_CYCLES and TIMEOUT_CYCLES localparams.
- Sub-module `debounce_sync`:
  - Parameter DEBOUNCE_CYCLES.
  - Ports: clk, rst, raw in; level, rise, fall out.
  - Instantiated three times.
- The top level holds the presence FSM and the timeout timer.

## Test plan
Use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=20 for all scenarios.
- Clean btn_mode_raw press at edge 0, held 10 cycles -> `a`=1 only in the cycle after edge 5; `b`, `c`, `d` stay 0; no pulse on release.
- btn_manual_raw bounces 1,0,1,1,0 (glitches of 3 cycles or fewer), then settles high -> exactly one `b` pulse, 6 edges after the final settle; no pulse from the glitches.
- presence_raw rises, then falls and stays low for 30 cycles -> `d` pulse once; `hold_active` high for 20 cycles; `c` pulse exactly 20 edges after `presence_stable` falls; state IDLE afterwards.
- Presence returns at HOLD timer value 10 -> `hold_active` drops, no `c` and no `d`. A later 20-cycle vacancy then yields `c`.
- Presence rise coincides with the expiry edge -> `c` stays 0 and the state is OCCUPIED.
- rst asserted in HOLD with timer at 15 while btn_mode_raw is held high -> all outputs 0 immediately. After release, `a` pulses once 6 edges later; no `c` is produced.
